// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding, baud rate
// codes, and the 16x oversampling divisor table derived from the clock rate.
// No logic of its own; imported by uart_receiver and baud_controller.
package uart_receiver_pkg;

  // Receiver frame FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Rate codes as presented on baud_select.
  localparam logic [2:0] BAUD_300    = 3'd0;
  localparam logic [2:0] BAUD_1200   = 3'd1;
  localparam logic [2:0] BAUD_4800   = 3'd2;
  localparam logic [2:0] BAUD_9600   = 3'd3;
  localparam logic [2:0] BAUD_19200  = 3'd4;
  localparam logic [2:0] BAUD_38400  = 3'd5;
  localparam logic [2:0] BAUD_57600  = 3'd6;
  localparam logic [2:0] BAUD_115200 = 3'd7;

  // Divisor counter width: 20 bits covers 300 baud up to roughly 5 GHz clocks.
  localparam int DIV_W = 20;

  // Oversample tick positions within one bit time.
  localparam logic [3:0] TICK_MID  = 4'd7;   // 8th tick after the falling edge
  localparam logic [3:0] TICK_LAST = 4'd15;  // 16th tick: next bit centre

  function automatic int unsigned baud_rate(input logic [2:0] code);
    case (code)
      BAUD_300:    return 300;
      BAUD_1200:   return 1200;
      BAUD_4800:   return 4800;
      BAUD_9600:   return 9600;
      BAUD_19200:  return 19200;
      BAUD_38400:  return 38400;
      BAUD_57600:  return 57600;
      default:     return 115200;
    endcase
  endfunction

  // round(clk_hz / (16 * baud)), never below 1 so the tick always advances.
  function automatic logic [DIV_W-1:0] baud_divisor(input int unsigned clk_hz,
                                                    input logic [2:0]  code);
    int unsigned rate;
    int unsigned quo;
    rate = baud_rate(code);
    quo  = (clk_hz + 8 * rate) / (16 * rate);
    if (quo == 0) quo = 1;
    return quo[DIV_W-1:0];
  endfunction

endpackage

// File: rtl/baud_controller.sv
// 16x-baud oversampling tick generator, shared by the receive and transmit paths.
// Latency: first tick DIV clocks after i_run rises, then one tick every DIV clocks.
// Backpressure: none; counter is held at zero whenever i_run is low.
// Ports: clk, reset (async, active low), i_run (count enable), i_baud_sel (rate
//        code, expected stable while running), o_tick (one-clock pulse).
module baud_controller #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_run,
  input  logic [2:0] i_baud_sel,
  output logic       o_tick
);
  import uart_receiver_pkg::*;

  logic [DIV_W-1:0] w_div_last;
  logic [DIV_W-1:0] r_div_cnt;
  logic             w_wrap;

  assign w_div_last = baud_divisor(CLK_HZ, i_baud_sel) - DIV_W'(1);
  assign w_wrap     = (r_div_cnt == w_div_last);
  assign o_tick     = i_run && w_wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt <= '0;
    end else if (!i_run || w_wrap) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits LSB first, even parity, 1 stop, 16x oversampled.
// Latency: byte and status appear one clk after the stop-bit centre sample.
// Backpressure: none; outputs are levels that hold until the next validated start.
// Ports: clk, reset (async, active low), baud_select (rate code latched at start),
//        Rx_EN (enable), RxD (async serial line), Rx_DATA/Rx_VALID/Rx_PERROR/Rx_FERROR.
module uart_receiver #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);
  import uart_receiver_pkg::*;

  // Synchronizer and edge history
  logic       r_rxd_meta;
  logic       r_rxd_sync;
  logic       r_rxd_prev;
  logic       w_fall;

  // Baud control
  logic [2:0] r_baud_sel;
  logic       w_baud_run;
  logic       w_tick;

  // FSM and datapath
  rx_state_t  r_state;
  rx_state_t  w_state_nxt;
  logic [3:0] r_tick_cnt;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_par_bit;
  logic       w_mid;
  logic       w_bit_end;
  logic       w_start_det;
  logic       w_start_ok;
  logic       w_data_smp;
  logic       w_par_smp;
  logic       w_stop_smp;
  logic       w_perr;
  logic       w_ferr;

  // Output registers
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_perr;
  logic       r_ferr;

  // ---------------------------------------------------------------------------
  // RxD synchronizer. r_rxd_prev keeps running even while disabled so that a
  // line already low when Rx_EN rises, or held low after a break, never looks
  // like a fresh falling edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_rxd_meta <= RxD;
      r_rxd_sync <= r_rxd_meta;
      r_rxd_prev <= r_rxd_sync;
    end
  end

  assign w_fall = r_rxd_prev & ~r_rxd_sync;

  // ---------------------------------------------------------------------------
  // Baud rate is captured on start detection so a mid-frame change of
  // baud_select cannot disturb the frame in flight. The tick counter is idle
  // (held at zero) in IDLE, so it restarts aligned to the detected edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_baud_sel <= BAUD_300;
    end else if (w_start_det) begin
      r_baud_sel <= baud_select;
    end
  end

  assign w_baud_run = (r_state != ST_IDLE);

  baud_controller #(
    .CLK_HZ(CLK_HZ)
  ) u_baud_controller (
    .clk        (clk),
    .reset      (reset),
    .i_run      (w_baud_run),
    .i_baud_sel (r_baud_sel),
    .o_tick     (w_tick)
  );

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  assign w_mid     = w_tick && (r_tick_cnt == TICK_MID);
  assign w_bit_end = w_tick && (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_det = 1'b0;
    w_start_ok  = 1'b0;
    w_data_smp  = 1'b0;
    w_par_smp   = 1'b0;
    w_stop_smp  = 1'b0;
    if (!Rx_EN) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            w_start_det = 1'b1;
            w_state_nxt = ST_START;
          end
        end
        ST_START: begin
          // Line back high at the start-bit centre: treat as a glitch.
          if (w_mid) begin
            if (r_rxd_sync) begin
              w_state_nxt = ST_IDLE;
            end else begin
              w_start_ok  = 1'b1;
              w_state_nxt = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            w_data_smp = 1'b1;
            if (r_bit_cnt == 3'd7) begin
              w_state_nxt = ST_PARITY;
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            w_par_smp   = 1'b1;
            w_state_nxt = ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            w_stop_smp  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Tick and bit counters. The tick counter is zeroed at the start-bit centre
  // so every later bit is sampled exactly 16 ticks on, at its own centre.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_cnt <= 4'd0;
    end else if ((w_state_nxt == ST_IDLE) || w_start_ok) begin
      r_tick_cnt <= 4'd0;
    end else if (w_tick) begin
      r_tick_cnt <= r_tick_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bit_cnt <= 3'd0;
    end else if ((w_state_nxt == ST_IDLE) || w_start_ok) begin
      r_bit_cnt <= 3'd0;
    end else if (w_data_smp) begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Shift register (LSB arrives first, so shift in from the top) and parity bit.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift   <= 8'h00;
      r_par_bit <= 1'b0;
    end else begin
      if (w_data_smp) begin
        r_shift <= {r_rxd_sync, r_shift[7:1]};
      end
      if (w_par_smp) begin
        r_par_bit <= r_rxd_sync;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers. Data and all flags change on the same edge so a
  // downstream consumer never sees a new byte paired with stale status.
  // ---------------------------------------------------------------------------
  assign w_perr = (^r_shift) ^ r_par_bit;
  assign w_ferr = ~r_rxd_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else if (w_stop_smp) begin
      r_data  <= r_shift;
      r_perr  <= w_perr;
      r_ferr  <= w_ferr;
      r_valid <= ~(w_perr | w_ferr);
    end else if (w_start_ok) begin
      // Validated start: status clears, the previous byte stays visible.
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end
  end

  assign Rx_DATA   = r_data;
  assign Rx_VALID  = r_valid;
  assign Rx_PERROR = r_perr;
  assign Rx_FERROR = r_ferr;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: stimulus queues expected frame results,
// an independent monitor pops and compares on each output update.
// Clock 3.6864 MHz so divisors are small: 9600->24, 57600->4, 115200->2.
module tb_uart_receiver;
  import uart_receiver_pkg::*;

  localparam int unsigned TB_CLK_HZ = 3_686_400;
  localparam int DIV_9600   = 24;
  localparam int DIV_57600  = 4;
  localparam int DIV_115200 = 2;

  logic       clk;
  logic       rst_n;
  logic [2:0] baud_select;
  logic       Rx_EN;
  logic       RxD;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_PERROR;
  logic       Rx_FERROR;

  uart_receiver #(
    .CLK_HZ(TB_CLK_HZ)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .baud_select (baud_select),
    .Rx_EN       (Rx_EN),
    .RxD         (RxD),
    .Rx_DATA     (Rx_DATA),
    .Rx_VALID    (Rx_VALID),
    .Rx_PERROR   (Rx_PERROR),
    .Rx_FERROR   (Rx_FERROR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic       p;
    logic       f;
    int         lo;
    int         hi;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   errors    = 0;
  int   rx_events = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every frame ends with exactly one flag set, and a validated
  // start clears them all, so a zero-to-nonzero flag change marks an update.
  logic [2:0] prev_fl = 3'b000;
  exp_t       mon_e;
  always @(negedge clk) begin
    logic [2:0] fl;
    fl = {Rx_VALID, Rx_PERROR, Rx_FERROR};
    if (rst_n && (prev_fl == 3'b000) && (fl != 3'b000)) begin
      rx_events++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual data=%0h flags=%b required=no update", Rx_DATA, fl);
      end else begin
        mon_e = sb.pop_front();
        check("rx_data", 32'(Rx_DATA), 32'(mon_e.d));
        check("rx_flags_vpf", 32'(fl), 32'({mon_e.v, mon_e.p, mon_e.f}));
        checks++;
        if (cyc < mon_e.lo || cyc > mon_e.hi) begin
          errors++;
          $display("FAIL update_latency actual cycle=%0d required %0d..%0d", cyc, mon_e.lo, mon_e.hi);
        end
      end
    end
    prev_fl = fl;
  end

  task automatic send_bits(input logic [10:0] frame, input int nbits, input int div);
    for (int i = 0; i < nbits; i++) begin
      RxD = frame[i];
      repeat (16 * div) @(negedge clk);
    end
  endtask

  // Sends one full frame; the line is left at the stop-bit level.
  // Stop-bit centre is 10.5 bit times = 168*div clocks after the start edge.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int div, input logic [7:0] ed,
                            input logic ev, input logic ep, input logic ef);
    exp_t e;
    e.d  = ed;
    e.v  = ev;
    e.p  = ep;
    e.f  = ef;
    e.lo = cyc + 168 * div;
    e.hi = e.lo + 5;
    sb.push_back(e);
    send_bits({stp, par, d, 1'b0}, 11, div);
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] d,
                               input logic v, input logic p, input logic f);
    check({tag, "_data"},   32'(Rx_DATA),   32'(d));
    check({tag, "_valid"},  32'(Rx_VALID),  32'(v));
    check({tag, "_perror"}, 32'(Rx_PERROR), 32'(p));
    check({tag, "_ferror"}, 32'(Rx_FERROR), 32'(f));
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog actual=timeout required=bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    RxD         = 1'b1;
    Rx_EN       = 1'b1;
    baud_select = BAUD_9600;

    // Divisor table at the default 50 MHz and at the bench clock.
    check("div50_300",    32'(baud_divisor(50_000_000, BAUD_300)),    32'd10417);
    check("div50_9600",   32'(baud_divisor(50_000_000, BAUD_9600)),   32'd326);
    check("div50_57600",  32'(baud_divisor(50_000_000, BAUD_57600)),  32'd54);
    check("div50_115200", 32'(baud_divisor(50_000_000, BAUD_115200)), 32'd27);
    check("divtb_9600",   32'(baud_divisor(TB_CLK_HZ, BAUD_9600)),    32'd24);
    check("divtb_115200", 32'(baud_divisor(TB_CLK_HZ, BAUD_115200)),  32'd2);

    repeat (5) @(negedge clk);
    check_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 9600: 0x5A, even parity 0, stop 1 -> good byte.
    send_frame(8'h5A, 1'b0, 1'b1, DIV_9600, 8'h5A, 1'b1, 1'b0, 1'b0);
    wait_drain(20);

    // 115200: 0x5A with parity 1 -> parity error; baud_select changes mid-frame.
    baud_select = BAUD_115200;
    fork
      send_frame(8'h5A, 1'b1, 1'b1, DIV_115200, 8'h5A, 1'b0, 1'b1, 1'b0);
      begin
        repeat (60) @(negedge clk);
        baud_select = BAUD_300;
      end
    join
    baud_select = BAUD_115200;
    wait_drain(400);

    // 9600: 0x3C with stop 0, then line held low (break).
    baud_select = BAUD_9600;
    send_frame(8'h3C, 1'b0, 1'b0, DIV_9600, 8'h3C, 1'b0, 1'b0, 1'b1);
    wait_drain(20);
    repeat (2 * 176 * DIV_9600) @(negedge clk);
    check_outputs("break_hold", 8'h3C, 1'b0, 1'b0, 1'b1);
    RxD = 1'b1;
    repeat (400) @(negedge clk);

    // 4-tick low glitch: rejected at the start-bit centre, outputs untouched.
    RxD = 1'b0;
    repeat (4 * DIV_9600) @(negedge clk);
    RxD = 1'b1;
    repeat (32 * DIV_9600) @(negedge clk);
    check_outputs("glitch", 8'h3C, 1'b0, 1'b0, 1'b1);

    // Rx_EN dropped mid-frame at 115200: frame discarded. The validated start
    // already cleared the status flags; the old byte is still held.
    baud_select = BAUD_115200;
    send_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 5, DIV_115200);
    Rx_EN = 1'b0;
    RxD   = 1'b1;
    repeat (50) @(negedge clk);
    Rx_EN = 1'b1;
    repeat (400) @(negedge clk);
    check_outputs("en_drop", 8'h3C, 1'b0, 1'b0, 1'b0);

    // Rx_EN rising while the line is already low: no start.
    Rx_EN = 1'b0;
    RxD   = 1'b0;
    repeat (10) @(negedge clk);
    Rx_EN = 1'b1;
    repeat (400) @(negedge clk);
    RxD = 1'b1;
    repeat (50) @(negedge clk);
    check_outputs("en_rise_low", 8'h3C, 1'b0, 1'b0, 1'b0);

    // 57600 back-to-back 0x12 (parity 0) then 0x34 (parity 1).
    baud_select = BAUD_57600;
    send_frame(8'h12, 1'b0, 1'b1, DIV_57600, 8'h12, 1'b1, 1'b0, 1'b0);
    send_frame(8'h34, 1'b1, 1'b1, DIV_57600, 8'h34, 1'b1, 1'b0, 1'b0);
    wait_drain(20);

    // Another 0x34 frame cut by reset, then 0x56 (parity 0) received cleanly.
    send_bits({1'b1, 1'b1, 8'h34, 1'b0}, 5, DIV_57600);
    rst_n = 1'b0;
    RxD   = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check_outputs("post_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(8'h56, 1'b0, 1'b1, DIV_57600, 8'h56, 1'b1, 1'b0, 1'b0);
    wait_drain(20);

    repeat (20) @(negedge clk);
    check("total_updates", 32'(rx_events), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency that the baud divisors are computed from.
REQ-002 clk  input  1  system clock, rising edge; the block SHALL use one clock only.
REQ-003 reset  input  1  asynchronous active-low reset.
REQ-004 baud_select  input  3  rate code: 0..7 = 300, 1200, 4800, 9600, 19200, 38400, 57600, 115200 baud.
REQ-005 Rx_EN  input  1  receiver enable; active-high.
REQ-006 RxD  input  1  serial line; idle high; asynchronous to clk.
REQ-007 Rx_DATA  output  8  last received byte.
REQ-008 Rx_VALID  output  1  last byte received without error; level signal.
REQ-009 Rx_PERROR  output  1  parity mismatch on the last frame.
REQ-010 Rx_FERROR  output  1  stop bit sampled low on the last frame.

Function
REQ-011 Frame format SHALL be: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (1).
REQ-012 RxD SHALL pass through a 2-flop synchronizer before any use.
REQ-013 The oversampling tick SHALL be 16x baud, with divisor = round(CLK_HZ/(16*baud)); at 50 MHz the divisors are 10417, 2604, 651, 326, 163, 81, 54, 27.
REQ-014 baud_select SHALL be latched on start detection; changes during a frame SHALL NOT affect that frame.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE -> START SHALL occur on a synchronized high-to-low transition of RxD while Rx_EN=1; the tick counter restarts at 0.
REQ-017 START: at tick 8, if RxD=1 the FSM SHALL return to IDLE as a glitch, with no output change; otherwise it SHALL go to DATA.
REQ-018 DATA: each bit SHALL be sampled every 16 ticks after the start mid-point; after 8 samples the FSM SHALL go to PARITY.
REQ-019 PARITY: one sample SHALL be taken, then the FSM SHALL go to STOP.
REQ-020 STOP: one sample SHALL be taken; on that same tick the FSM SHALL go to IDLE and the outputs SHALL update on the next clk edge.
REQ-021 On the output update, Rx_DATA SHALL take the received byte whether or not the frame has an error.
REQ-022 On the output update, Rx_PERROR = (XOR of data bits) XOR parity bit.
REQ-023 On the output update, Rx_FERROR = NOT stop bit.
REQ-024 On the output update, Rx_VALID = NOT(Rx_PERROR OR Rx_FERROR).
REQ-025 Rx_DATA, Rx_VALID and the error flags SHALL hold until the next validated start (REQ-017); at that point Rx_VALID, Rx_PERROR and Rx_FERROR SHALL clear, and Rx_DATA SHALL hold.
REQ-026 A byte update SHALL therefore always change Rx_DATA with Rx_VALID already settled on the same edge, as the downstream byte-pair decoder requires.
REQ-027 If RxD is held low (break), the frame SHALL end with Rx_FERROR=1 and Rx_VALID=0; no new start SHALL be detected until RxD has been seen high.
REQ-028 If Rx_EN=0, the FSM SHALL be forced to IDLE, any frame in progress SHALL be discarded, and the outputs SHALL hold.
REQ-029 If Rx_EN rises while RxD is already low, no start SHALL be detected; a falling edge is required.
REQ-030 Back-to-back frames SHALL be accepted with zero idle time after the stop mid-point.

Reset
REQ-031 reset low SHALL, asynchronously: FSM=IDLE, counters=0, synchronizer flops=1, Rx_DATA=8'h00, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame; after release, reception SHALL resume on the next falling edge of RxD.

Structure
REQ-033 The shared package SHALL hold the FSM state encoding, the baud code constants, and the divisor table, computed from CLK_HZ.
REQ-034 One sub-module, baud_controller, SHALL generate the 16x tick from the latched baud_select; the transmitter side SHALL be able to reuse it.
REQ-035 The top level SHALL contain the synchronizer, the FSM, the bit and tick counters, the shift register, and the output registers.

Verification
REQ-036 At 9600 baud, frame 0x5A with parity 0 and stop 1 -> Rx_DATA=0x5A, Rx_VALID=1, both error flags 0, within 2 clk after the stop mid-sample.
REQ-037 At 115200 baud, 0x5A with parity bit 1 -> Rx_DATA=0x5A, Rx_PERROR=1, Rx_VALID=0.
REQ-038 At 9600 baud, 0x3C with stop bit 0 -> Rx_FERROR=1, Rx_VALID=0; then RxD held low -> no new frame until RxD goes high.
REQ-039 A 4-tick low glitch on idle RxD -> FSM returns to IDLE; outputs unchanged.
REQ-040 Back-to-back frames 0x12 then 0x34 at 57600 baud -> two Rx_DATA updates with Rx_VALID=1 on each; reset pulsed mid-way through the 0x34 frame -> all outputs are at reset values and the next frame 0x56 is received correctly.
